// File: rtl/iq_issue_ctl.sv
// Issue-queue extraction controller: issues an in-order hazard-free prefix of the head window and owns the register scoreboard.
// Latency: one cycle from window presentation to issue_valid; issue_stall holds the issued group and blocks consumption.
// Optional IQ_ISSUE_WB_BYPASS_EN: same-cycle writebacks release readiness (back-to-back dependent issue).
package iq_issue_ctl_pkg;
    typedef struct packed {
        logic [5:0]  tag;
        logic [25:0] payload;
    } iq_entry_t;
endpackage

module iq_issue_ctl #(
    parameter type T            = iq_issue_ctl_pkg::iq_entry_t,
    parameter int  EXT_COUNT    = 4,
    parameter int  ISSUE_WIDTH  = 2,
    parameter int  NUM_REGS     = 32,
    parameter int  WB_PORTS     = 2,
    parameter int  REGLOG2      = $clog2(NUM_REGS),
    parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [EXT_COUNT-1:0]    iq_valid,
    input  T                        iq_entry  [EXT_COUNT],
    input  logic [REGLOG2-1:0]      iq_rs     [EXT_COUNT],
    input  logic [REGLOG2-1:0]      iq_rt     [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    iq_rs_use,
    input  logic [EXT_COUNT-1:0]    iq_rt_use,
    input  logic [REGLOG2-1:0]      iq_rd     [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    iq_rd_we,
    input  logic [WB_PORTS-1:0]     wb_valid,
    input  logic [REGLOG2-1:0]      wb_reg    [WB_PORTS],
    input  logic                    issue_stall,
    output logic                    ext_enable,
    output logic [EXTCOUNTLOG2-1:0] ext_consumed,
    output logic [ISSUE_WIDTH-1:0]  issue_valid,
    output T                        issue_entry [ISSUE_WIDTH]
);

    logic [NUM_REGS-1:0]    busy;
    logic [NUM_REGS-1:0]    busy_eff;
    logic [NUM_REGS-1:0]    busy_next;
    logic [NUM_REGS-1:0]    wb_clr;
    logic [ISSUE_WIDTH-1:0] ready;
    logic [EXTCOUNTLOG2:0]  n_sel;
    logic                   run;

    always_comb begin
        wb_clr = '0;
        for (int p = 0; p < WB_PORTS; p++)
            if (wb_valid[p]) wb_clr[wb_reg[p]] = 1'b1;
    end

`ifdef IQ_ISSUE_WB_BYPASS_EN
    assign busy_eff = busy & ~wb_clr;
`else
    assign busy_eff = busy;
`endif

    // Only slots that can land inside the issue group need a readiness verdict.
    always_comb begin
        ready = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ready[i] = iq_valid[i];
            if (iq_rs_use[i] && busy_eff[iq_rs[i]]) ready[i] = 1'b0;
            if (iq_rt_use[i] && busy_eff[iq_rt[i]]) ready[i] = 1'b0;
            if (iq_rd_we[i]  && busy_eff[iq_rd[i]]) ready[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (iq_rd_we[j] && iq_rd[j] != '0) begin
                    if ((iq_rs_use[i] && iq_rs[i] == iq_rd[j]) ||
                        (iq_rt_use[i] && iq_rt[i] == iq_rd[j]) ||
                        (iq_rd_we[i]  && iq_rd[i] == iq_rd[j]))
                        ready[i] = 1'b0;
                end
            end
        end
    end

    // First blocked slot ends the group; younger ready slots never bypass it.
    always_comb begin
        n_sel = '0;
        run   = 1'b1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            run = run & ready[i];
            if (run) n_sel = (EXTCOUNTLOG2+1)'(i + 1);
        end
    end

    assign ext_enable   = (n_sel != '0) && !issue_stall && !flush && !reset;
    assign ext_consumed = ext_enable ? EXTCOUNTLOG2'(n_sel - 1'b1) : '0;

    always_comb begin
        busy_next = busy & ~wb_clr;
        if (ext_enable)
            for (int k = 0; k < ISSUE_WIDTH; k++)
                if ((EXTCOUNTLOG2+1)'(k) < n_sel && iq_rd_we[k]) busy_next[iq_rd[k]] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_valid <= '0;
            busy        <= '0;
            for (int k = 0; k < ISSUE_WIDTH; k++) issue_entry[k] <= '0;
        end else if (flush) begin
            issue_valid <= '0;
            busy        <= '0;
        end else begin
            busy <= busy_next;
            if (ext_enable) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    issue_valid[k] <= ((EXTCOUNTLOG2+1)'(k) < n_sel);
                    issue_entry[k] <= iq_entry[k];
                end
            end else if (!issue_stall) begin
                issue_valid <= '0;
            end
        end
    end

    // Window slots beyond the issue width are never examined.
    if (EXT_COUNT > ISSUE_WIDTH) begin : g_tail
        logic unused_tail;
        always_comb begin
            unused_tail = 1'b0;
            for (int i = ISSUE_WIDTH; i < EXT_COUNT; i++)
                unused_tail = unused_tail ^ iq_valid[i] ^ (^iq_entry[i]) ^ (^iq_rs[i]) ^ (^iq_rt[i])
                            ^ iq_rs_use[i] ^ iq_rt_use[i] ^ (^iq_rd[i]) ^ iq_rd_we[i];
        end
    end

endmodule
